// File: rtl/ysyx_22041071_wb_arbiter_pkg.sv
// Shared widths, commit-source encoding and small helpers for the
// writeback arbiter that shares the register-file write port.
package ysyx_22041071_wb_arbiter_pkg;

  localparam int ysyx_22041071_ADDR_BUS = 64;
  localparam int ysyx_22041071_INS_BUS  = 32;
  localparam int ysyx_22041071_DATA_BUS = 64;
  localparam int ysyx_22041071_REG_W    = 5;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_MDU  = 1'b1
  } commit_src_e;

  // x0 is hardwired to zero, so a write to it must never reach the register file.
  function automatic logic rf_write_en(input logic wen, input logic [ysyx_22041071_REG_W-1:0] rd);
    return wen && (rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_22041071_wb_grant.sv
// Combinational grant/ready logic with a starvation counter that forces
// the pipeline stream (A) through after STARVE_LIMIT consecutive MDU wins.
module ysyx_22041071_wb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_ready_a,
  output logic o_ready_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_a;
  logic             w_ready_a;
  logic             w_ready_b;
  logic             w_grant_a;
  logic             w_grant_b;

  assign w_force_a = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Readies are masked during reset so nothing is accepted that cannot commit.
  assign w_ready_b = ~i_reset & (~w_force_a | ~i_valid_a);
  assign w_ready_a = ~i_reset & (~i_valid_b | w_force_a);
  assign w_grant_b = i_valid_b & w_ready_b;
  assign w_grant_a = i_valid_a & w_ready_a;

  assign o_ready_a = w_ready_a;
  assign o_ready_b = w_ready_b;
  assign o_grant_a = w_grant_a;
  assign o_grant_b = w_grant_b;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (~i_valid_a | w_grant_a) begin
      r_starve_cnt <= '0;
    end else if (w_grant_b && !w_force_a) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22041071_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stream (A) and the MDU (B); registers the winner and counts retirements.
module ysyx_22041071_wb_arbiter
  import ysyx_22041071_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ysyx_22041071_ADDR_BUS,
  parameter int DATA_W       = ysyx_22041071_DATA_BUS,
  parameter int INS_W        = ysyx_22041071_INS_BUS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [ADDR_W-1:0] pc_a,
  input  logic [INS_W-1:0]  ins_a,
  input  logic              wen_a,
  input  logic [4:0]        rd_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              valid_b,
  output logic              ready_b,
  input  logic [ADDR_W-1:0] pc_b,
  input  logic [INS_W-1:0]  ins_b,
  input  logic              wen_b,
  input  logic [4:0]        rd_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              reg_w_en,
  output logic [4:0]        rdest,
  output logic [DATA_W-1:0] WB_data,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_pc,
  output logic [INS_W-1:0]  commit_ins,
  output logic              commit_src,
  output logic [63:0]       instret
);

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic [ADDR_W-1:0] w_pc;
  logic [INS_W-1:0]  w_ins;
  logic              w_wen;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_data;
  commit_src_e       w_src;

  logic              r_reg_w_en;
  logic [4:0]        r_rdest;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_commit_valid;
  logic [ADDR_W-1:0] r_commit_pc;
  logic [INS_W-1:0]  r_commit_ins;
  commit_src_e       r_commit_src;
  logic [63:0]       r_instret;

  ysyx_22041071_wb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .i_reset  (reset),
    .i_valid_a(valid_a),
    .i_valid_b(valid_b),
    .o_ready_a(ready_a),
    .o_ready_b(ready_b),
    .o_grant_a(w_grant_a),
    .o_grant_b(w_grant_b)
  );

  assign w_grant = w_grant_a | w_grant_b;

  always_comb begin
    w_src  = SRC_PIPE;
    w_pc   = pc_a;
    w_ins  = ins_a;
    w_wen  = wen_a;
    w_rd   = rd_a;
    w_data = data_a;
    if (w_grant_b) begin
      w_src  = SRC_MDU;
      w_pc   = pc_b;
      w_ins  = ins_b;
      w_wen  = wen_b;
      w_rd   = rd_b;
      w_data = data_b;
    end
  end

  // Payload registers hold across idle cycles; only the strobes drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_w_en     <= 1'b0;
      r_rdest        <= '0;
      r_wb_data      <= '0;
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
      r_commit_ins   <= '0;
      r_commit_src   <= SRC_PIPE;
      r_instret      <= '0;
    end else begin
      r_commit_valid <= w_grant;
      r_reg_w_en     <= w_grant & rf_write_en(w_wen, w_rd);
      if (w_grant) begin
        r_rdest      <= w_rd;
        r_wb_data    <= w_data;
        r_commit_pc  <= w_pc;
        r_commit_ins <= w_ins;
        r_commit_src <= w_src;
        r_instret    <= r_instret + 64'd1;
      end
    end
  end

  assign reg_w_en     = r_reg_w_en;
  assign rdest        = r_rdest;
  assign WB_data      = r_wb_data;
  assign commit_valid = r_commit_valid;
  assign commit_pc    = r_commit_pc;
  assign commit_ins   = r_commit_ins;
  assign commit_src   = r_commit_src;
  assign instret      = r_instret;

endmodule
